// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle accumulator CPU with ready/valid memory handshakes.
// Ports: i_clock/i_reset, program fetch (o_PmAddr, o_PmReq, i_PmValid,
//   i_Instruction), data access (o_DmAddr, o_Rd, o_Wr, o_InData,
//   i_DmReady, i_OutData), status (o_Acc, o_Halted, o_Illegal,
//   o_InstrCount). Define CPU_MC_INSTR_COUNT_EN to enable the
//   retired-instruction counter; otherwise o_InstrCount is 0.
module cpu_mc #(
  parameter int NBITS_O = 11,
  parameter int NBITS_D = 16,
  parameter int OPCODE  = 5
) (
  input  logic               i_clock,
  input  logic               i_reset,
  output logic [NBITS_O-1:0] o_PmAddr,
  output logic               o_PmReq,
  input  logic               i_PmValid,
  input  logic [NBITS_D-1:0] i_Instruction,
  output logic [NBITS_O-1:0] o_DmAddr,
  output logic               o_Rd,
  output logic               o_Wr,
  output logic [NBITS_D-1:0] o_InData,
  input  logic               i_DmReady,
  input  logic [NBITS_D-1:0] i_OutData,
  output logic [NBITS_D-1:0] o_Acc,
  output logic               o_Halted,
  output logic               o_Illegal,
  output logic [31:0]        o_InstrCount
);

  typedef enum logic [1:0] {
    FETCH, EXEC, MEM, HALT
  } state_t;

  localparam logic [OPCODE-1:0] OP_HLT  = OPCODE'(5'b00000);
  localparam logic [OPCODE-1:0] OP_STO  = OPCODE'(5'b00001);
  localparam logic [OPCODE-1:0] OP_LD   = OPCODE'(5'b00010);
  localparam logic [OPCODE-1:0] OP_LDI  = OPCODE'(5'b00011);
  localparam logic [OPCODE-1:0] OP_ADD  = OPCODE'(5'b00100);
  localparam logic [OPCODE-1:0] OP_ADDI = OPCODE'(5'b00101);
  localparam logic [OPCODE-1:0] OP_SUB  = OPCODE'(5'b00110);
  localparam logic [OPCODE-1:0] OP_SUBI = OPCODE'(5'b00111);
  localparam logic [OPCODE-1:0] OP_AND  = OPCODE'(5'b01000);
  localparam logic [OPCODE-1:0] OP_ANDI = OPCODE'(5'b01001);
  localparam logic [OPCODE-1:0] OP_OR   = OPCODE'(5'b01010);
  localparam logic [OPCODE-1:0] OP_ORI  = OPCODE'(5'b01011);
  localparam logic [OPCODE-1:0] OP_XOR  = OPCODE'(5'b01100);
  localparam logic [OPCODE-1:0] OP_XORI = OPCODE'(5'b01101);
  localparam logic [OPCODE-1:0] OP_SLL  = OPCODE'(5'b01110);
  localparam logic [OPCODE-1:0] OP_SRL  = OPCODE'(5'b01111);
  localparam logic [OPCODE-1:0] OP_JMP  = OPCODE'(5'b10000);
  localparam logic [OPCODE-1:0] OP_BEQ  = OPCODE'(5'b10001);
  localparam logic [OPCODE-1:0] OP_BNE  = OPCODE'(5'b10010);

  state_t             state, state_nx;
  logic [NBITS_O-1:0] pc, pc_nx, pc_inc;
  logic [NBITS_D-1:0] acc, acc_nx;
  logic [NBITS_D-1:0] ir, ir_nx;
  logic [NBITS_D-1:0] imm;
  logic [OPCODE-1:0]  opcode;
  logic [NBITS_O-1:0] operand;
  logic               pm_req, rd, wr, illegal;

  assign opcode  = ir[NBITS_D-1:NBITS_O];
  assign operand = ir[NBITS_O-1:0];
  assign imm     = {{(NBITS_D-NBITS_O){operand[NBITS_O-1]}}, operand};
  assign pc_inc  = pc + NBITS_O'(1);

  // Register and immediate ALU forms differ only in opcode bit 0,
  // so bits [3:1] select the operation for both.
  function automatic logic [NBITS_D-1:0] alu(
    input logic [2:0]         sel,
    input logic [NBITS_D-1:0] a,
    input logic [NBITS_D-1:0] b
  );
    case (sel)
      3'b010:  return a + b;
      3'b011:  return a - b;
      3'b100:  return a & b;
      3'b101:  return a | b;
      3'b110:  return a ^ b;
      default: return a;
    endcase
  endfunction

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state <= FETCH;
      pc    <= '0;
      acc   <= '0;
      ir    <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      acc   <= acc_nx;
      ir    <= ir_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    acc_nx   = acc;
    ir_nx    = ir;
    pm_req   = 1'b0;
    rd       = 1'b0;
    wr       = 1'b0;
    illegal  = 1'b0;
    unique case (state)
      FETCH: begin
        pm_req = 1'b1;
        if (i_PmValid) begin
          ir_nx    = i_Instruction;
          state_nx = EXEC;
        end
      end
      EXEC: begin
        state_nx = FETCH;
        pc_nx    = pc_inc;
        case (opcode)
          OP_HLT: begin
            state_nx = HALT;
            pc_nx    = pc;
          end
          OP_STO, OP_LD, OP_ADD, OP_SUB,
          OP_AND, OP_OR, OP_XOR: begin
            state_nx = MEM;
            pc_nx    = pc;
          end
          OP_LDI: acc_nx = imm;
          OP_ADDI, OP_SUBI, OP_ANDI,
          OP_ORI, OP_XORI:
            acc_nx = alu(opcode[3:1], acc, imm);
          OP_SLL: acc_nx = acc << operand[3:0];
          OP_SRL: acc_nx = acc >> operand[3:0];
          OP_JMP: pc_nx = operand;
          OP_BEQ: if (acc == '0) pc_nx = operand;
          OP_BNE: if (acc != '0) pc_nx = operand;
          default: illegal = 1'b1;
        endcase
      end
      MEM: begin
        wr = (opcode == OP_STO);
        rd = !wr;
        if (i_DmReady) begin
          pc_nx    = pc_inc;
          state_nx = FETCH;
          if (opcode == OP_LD)
            acc_nx = i_OutData;
          else if (rd)
            acc_nx = alu(opcode[3:1], acc, i_OutData);
        end
      end
      HALT: ;
    endcase
  end

  // FETCH is the reset state; mask the request while reset is held.
  assign o_PmReq   = pm_req & ~i_reset;
  assign o_PmAddr  = pc;
  assign o_Rd      = rd;
  assign o_Wr      = wr;
  assign o_DmAddr  = operand;
  assign o_InData  = acc;
  assign o_Acc     = acc;
  assign o_Halted  = (state == HALT);
  assign o_Illegal = illegal;

`ifdef CPU_MC_INSTR_COUNT_EN
  logic        retire;
  logic [31:0] icount;

  assign retire = (state == EXEC && state_nx != MEM)
               || (state == MEM && i_DmReady);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)
      icount <= '0;
    else if (retire)
      icount <= icount + 32'd1;
  end

  assign o_InstrCount = icount;
`else
  assign o_InstrCount = '0;
`endif

endmodule

// File: tb/tb_cpu_mc.sv
// tb_cpu_mc: scoreboard bench for cpu_mc with latency-configurable
// program and data memory models.
module tb_cpu_mc;

  localparam logic [1:0] EV_N = 2'd0;
  localparam logic [1:0] EV_F = 2'd1;
  localparam logic [1:0] EV_R = 2'd2;
  localparam logic [1:0] EV_W = 2'd3;

  localparam logic [4:0] HLT = 5'b00000, STO = 5'b00001;
  localparam logic [4:0] LD = 5'b00010, LDI = 5'b00011;
  localparam logic [4:0] ADD = 5'b00100, ADDI = 5'b00101;
  localparam logic [4:0] SUB = 5'b00110, SUBI = 5'b00111;
  localparam logic [4:0] AND = 5'b01000, ANDI = 5'b01001;
  localparam logic [4:0] OR = 5'b01010, ORI = 5'b01011;
  localparam logic [4:0] XOR = 5'b01100, XORI = 5'b01101;
  localparam logic [4:0] SLL = 5'b01110, SRL = 5'b01111;
  localparam logic [4:0] JMP = 5'b10000, BEQ = 5'b10001;
  localparam logic [4:0] BNE = 5'b10010;

  typedef struct packed {
    logic [1:0]  k;
    logic [10:0] a;
    logic [15:0] d;
  } ev_t;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [10:0] o_PmAddr;
  logic        o_PmReq;
  logic        i_PmValid;
  logic [15:0] i_Instruction;
  logic [10:0] o_DmAddr;
  logic        o_Rd, o_Wr;
  logic [15:0] o_InData;
  logic        i_DmReady;
  logic [15:0] i_OutData;
  logic [15:0] o_Acc;
  logic        o_Halted, o_Illegal;
  logic [31:0] o_InstrCount;

  logic [15:0] pmem [0:2047];
  logic [15:0] dmem [0:2047];
  int pm_lat = 0, dm_lat = 0, pm_cnt = 0, dm_cnt = 0;

  ev_t exp_q[$];
  int checks = 0, errors = 0;
  int rd_run = 0, last_rd_run = 0, rd_moves = 0;
  int ill_cycles = 0, rw_both = 0;
  logic [10:0] rd_addr = '0;

  cpu_mc dut (
    .i_clock(clk), .i_reset(i_reset),
    .o_PmAddr(o_PmAddr), .o_PmReq(o_PmReq),
    .i_PmValid(i_PmValid), .i_Instruction(i_Instruction),
    .o_DmAddr(o_DmAddr), .o_Rd(o_Rd), .o_Wr(o_Wr),
    .o_InData(o_InData), .i_DmReady(i_DmReady),
    .i_OutData(i_OutData), .o_Acc(o_Acc),
    .o_Halted(o_Halted), .o_Illegal(o_Illegal),
    .o_InstrCount(o_InstrCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic sb(input ev_t got);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got %h required none", got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL sb_event: got %h required %h", got, e);
      end
    end
  endtask

  // Memory models: respond after lat idle cycles of a held request.
  initial begin
    i_PmValid = 1'b0;
    i_DmReady = 1'b0;
    i_Instruction = '0;
    i_OutData = '0;
    forever begin
      @(posedge clk);
      #1;
      i_PmValid = 1'b0;
      i_DmReady = 1'b0;
      if (o_PmReq) begin
        if (pm_cnt >= pm_lat) begin
          i_PmValid = 1'b1;
          i_Instruction = pmem[o_PmAddr];
          pm_cnt = 0;
        end else pm_cnt++;
      end else pm_cnt = 0;
      if (o_Rd || o_Wr) begin
        if (dm_cnt >= dm_lat) begin
          i_DmReady = 1'b1;
          i_OutData = dmem[o_DmAddr];
          dm_cnt = 0;
        end else dm_cnt++;
      end else dm_cnt = 0;
    end
  end

  // Monitor: completed handshakes are checked against the queue.
  initial forever begin
    @(negedge clk);
    if (!i_reset) begin
      if (o_Rd && o_Wr) rw_both++;
      if (o_Illegal) ill_cycles++;
      if (o_PmReq && i_PmValid)
        sb({EV_F, o_PmAddr, 16'h0000});
      if (o_Rd) begin
        if (rd_run == 0) rd_addr = o_DmAddr;
        else if (o_DmAddr != rd_addr) rd_moves++;
        rd_run++;
      end else rd_run = 0;
      if ((o_Rd || o_Wr) && i_DmReady) begin
        if (o_Rd) begin
          sb({EV_R, o_DmAddr, 16'h0000});
          last_rd_run = rd_run;
          rd_run = 0;
        end else
          sb({EV_W, o_DmAddr, o_InData});
      end
    end
  end

  function automatic logic [15:0] enc(input logic [4:0] op,
                                      input logic [10:0] v);
    return {op, v};
  endfunction

  task automatic step(input logic [10:0] pc,
                      input logic [15:0] ins,
                      input logic [1:0]  k,
                      input logic [10:0] a,
                      input logic [15:0] d);
    pmem[pc] = ins;
    exp_q.push_back({EV_F, pc, 16'h0000});
    if (k != EV_N) exp_q.push_back({k, a, d});
  endtask

  task automatic begin_test();
    i_reset = 1'b1;
    #1;
    exp_q.delete();
    for (int i = 0; i < 2048; i++) pmem[i] = '0;
    pm_lat = 0;
    dm_lat = 0;
    ill_cycles = 0;
    rw_both = 0;
    last_rd_run = 0;
    rd_moves = 0;
  endtask

  task automatic release_rst();
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_reset = 1'b0;
  endtask

  task automatic run(input string name, input logic [10:0] hpc);
    int n = 0;
    while (!o_Halted && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk({name, "_halted"}, 32'(o_Halted), 32'd1);
    chk({name, "_halt_pc"}, 32'(o_PmAddr), 32'(hpc));
    chk({name, "_sb_left"}, exp_q.size(), 32'd0);
    chk({name, "_rd_wr_both"}, rw_both, 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2048; i++) dmem[i] = '0;
    dmem[11'h020] = 16'hFFFF;
    dmem[11'h050] = 16'h1234;
    dmem[11'h051] = 16'h00F0;

    // Reset state
    begin_test();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pmreq", 32'(o_PmReq), 0);
    chk("rst_rd", 32'(o_Rd), 0);
    chk("rst_wr", 32'(o_Wr), 0);
    chk("rst_halted", 32'(o_Halted), 0);
    chk("rst_illegal", 32'(o_Illegal), 0);
    chk("rst_dmaddr", 32'(o_DmAddr), 0);
    chk("rst_pmaddr", 32'(o_PmAddr), 0);
    chk("rst_acc", 32'(o_Acc), 0);
    chk("rst_icount", o_InstrCount, 0);

    // T1: LDI 5; ADDI 3; STO 0x010; HLT
    step(0, enc(LDI, 5), EV_N, 0, 0);
    step(1, enc(ADDI, 3), EV_N, 0, 0);
    step(2, enc(STO, 11'h010), EV_W, 11'h010, 16'h0008);
    step(3, enc(HLT, 0), EV_N, 0, 0);
    release_rst();
    run("t1", 11'd3);
    chk("t1_acc", 32'(o_Acc), 32'h0008);
`ifdef CPU_MC_INSTR_COUNT_EN
    chk("t1_icount", o_InstrCount, 32'd4);
`else
    chk("t1_icount", o_InstrCount, 32'd0);
`endif

    // T2: slow data memory, LD then SUBI
    begin_test();
    pm_lat = 1;
    dm_lat = 3;
    step(0, enc(LD, 11'h020), EV_R, 11'h020, 0);
    step(1, enc(STO, 11'h022), EV_W, 11'h022, 16'hFFFF);
    step(2, enc(SUBI, 1), EV_N, 0, 0);
    step(3, enc(STO, 11'h021), EV_W, 11'h021, 16'hFFFE);
    step(4, enc(HLT, 0), EV_N, 0, 0);
    release_rst();
    run("t2", 11'd4);
    chk("t2_rd_cycles", last_rd_run, 32'd4);
    chk("t2_addr_moves", rd_moves, 32'd0);
    chk("t2_acc", 32'(o_Acc), 32'hFFFE);

    // T3: branches taken and not taken
    begin_test();
    step(0, enc(LDI, 0), EV_N, 0, 0);
    step(1, enc(BEQ, 11'h100), EV_N, 0, 0);
    step(11'h100, enc(LDI, 1), EV_N, 0, 0);
    step(11'h101, enc(BNE, 11'h200), EV_N, 0, 0);
    step(11'h200, enc(LDI, 1), EV_N, 0, 0);
    step(11'h201, enc(BEQ, 11'h300), EV_N, 0, 0);
    step(11'h202, enc(HLT, 0), EV_N, 0, 0);
    release_rst();
    run("t3", 11'h202);

    // T4: wrap, sign extension, shifts, logic and memory ALU ops
    begin_test();
    step(0, enc(LDI, 11'h7FF), EV_N, 0, 0);
    step(1, enc(STO, 11'h040), EV_W, 11'h040, 16'hFFFF);
    step(2, enc(SRL, 1), EV_N, 0, 0);
    step(3, enc(ADDI, 1), EV_N, 0, 0);
    step(4, enc(STO, 11'h041), EV_W, 11'h041, 16'h8000);
    step(5, enc(LDI, 11'h7FF), EV_N, 0, 0);
    step(6, enc(SLL, 4), EV_N, 0, 0);
    step(7, enc(STO, 11'h042), EV_W, 11'h042, 16'hFFF0);
    step(8, enc(SRL, 8), EV_N, 0, 0);
    step(9, enc(STO, 11'h043), EV_W, 11'h043, 16'h00FF);
    step(10, enc(ANDI, 11'h00F), EV_N, 0, 0);
    step(11, enc(ORI, 11'h030), EV_N, 0, 0);
    step(12, enc(XORI, 11'h7FF), EV_N, 0, 0);
    step(13, enc(STO, 11'h044), EV_W, 11'h044, 16'hFFC0);
    step(14, enc(ADD, 11'h050), EV_R, 11'h050, 0);
    step(15, enc(STO, 11'h045), EV_W, 11'h045, 16'h11F4);
    step(16, enc(XOR, 11'h051), EV_R, 11'h051, 0);
    step(17, enc(SUB, 11'h050), EV_R, 11'h050, 0);
    step(18, enc(OR, 11'h051), EV_R, 11'h051, 0);
    step(19, enc(AND, 11'h050), EV_R, 11'h050, 0);
    step(20, enc(STO, 11'h046), EV_W, 11'h046, 16'h1230);
    step(21, enc(HLT, 0), EV_N, 0, 0);
    release_rst();
    run("t4", 11'd21);
    chk("t4_illegal", ill_cycles, 32'd0);

    // T5: illegal opcodes, JMP 0x7FF, PC wrap to 0
    begin_test();
    pm_lat = 2;
    step(0, enc(BNE, 11'h010), EV_N, 0, 0);
    step(1, enc(LDI, 11'h055), EV_N, 0, 0);
    step(2, enc(5'b11111, 0), EV_N, 0, 0);
    step(3, enc(5'b10011, 11'h123), EV_N, 0, 0);
    step(4, enc(STO, 11'h060), EV_W, 11'h060, 16'h0055);
    step(5, enc(JMP, 11'h7FF), EV_N, 0, 0);
    step(11'h7FF, enc(LDI, 1), EV_N, 0, 0);
    step(0, enc(BNE, 11'h010), EV_N, 0, 0);
    step(11'h010, enc(HLT, 0), EV_N, 0, 0);
    release_rst();
    run("t5", 11'h010);
    chk("t5_illegal_cycles", ill_cycles, 32'd2);
`ifdef CPU_MC_INSTR_COUNT_EN
    chk("t5_icount", o_InstrCount, 32'd9);
`else
    chk("t5_icount", o_InstrCount, 32'd0);
`endif

    // T6: reset while a write is pending
    begin_test();
    dm_lat = 20;
    step(0, enc(LDI, 9), EV_N, 0, 0);
    step(1, enc(STO, 11'h030), EV_N, 0, 0);
    release_rst();
    n = 0;
    while (!o_Wr && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_wr_seen", 32'(o_Wr), 32'd1);
    #2;
    i_reset = 1'b1;
    #1;
    chk("t6_wr_abort", 32'(o_Wr), 0);
    chk("t6_acc", 32'(o_Acc), 0);
    chk("t6_pc", 32'(o_PmAddr), 0);
    chk("t6_pmreq", 32'(o_PmReq), 0);
    chk("t6_sb_pre", exp_q.size(), 0);
    begin_test();
    step(0, enc(LDI, 9), EV_N, 0, 0);
    step(1, enc(STO, 11'h030), EV_W, 11'h030, 16'h0009);
    step(2, enc(HLT, 0), EV_N, 0, 0);
    release_rst();
    run("t6", 11'd2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
